// File: rtl/drive_nco_z_corr_bank.sv
// Bank of per-qubit NCO phase accumulators with virtual-Z correction.
// Each lane advances its carrier phase and integrates a detuning correction.

module drive_nco_z_corr_lane #(
    parameter int PHASE_WIDTH = 24
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   freq_we,
    input  logic                   det_we,
    input  logic [PHASE_WIDTH-1:0] cfg_data,
    input  logic                   phase_en,
    input  logic                   zc_en,
    input  logic                   zc_mode,
    input  logic                   zc_clr,
    output logic [PHASE_WIDTH-1:0] phase_out,
    output logic                   phase_vld
);
    logic [PHASE_WIDTH-1:0] freq_q, freq_d;
    logic [PHASE_WIDTH-1:0] det_q, det_d;
    logic [PHASE_WIDTH-1:0] acc_q, acc_d;
    logic [PHASE_WIDTH-1:0] zc_q, zc_d;
    logic [PHASE_WIDTH-1:0] out_q, out_d;
    logic                   vld_q, vld_d;

    // Accumulators read the pre-write config, so a same-cycle write lands next cycle.
    always_comb begin
        freq_d = freq_we ? cfg_data : freq_q;
        det_d  = det_we ? cfg_data : det_q;
        acc_d  = phase_en ? acc_q + freq_q : acc_q;
        zc_d   = zc_q;
        if (zc_clr)
            zc_d = '0;
        else if (zc_en && !zc_mode)
            zc_d = zc_q + det_q;
        out_d  = acc_q + zc_q;
        vld_d  = phase_en;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            freq_q <= '0;
            det_q  <= '0;
            acc_q  <= '0;
            zc_q   <= '0;
            out_q  <= '0;
            vld_q  <= 1'b0;
        end else begin
            freq_q <= freq_d;
            det_q  <= det_d;
            acc_q  <= acc_d;
            zc_q   <= zc_d;
            out_q  <= out_d;
            vld_q  <= vld_d;
        end
    end

    assign phase_out = out_q;
    assign phase_vld = vld_q;
endmodule

module drive_nco_z_corr_bank #(
    parameter int NUM_QUBIT_PER_BANK        = 16,
    parameter int QUBIT_ADDR_WIDTH_PER_BANK = 4,
    parameter int PHASE_WIDTH               = 24
) (
    input  logic                                       clk,
    input  logic                                       rst,
    input  logic [NUM_QUBIT_PER_BANK-1:0]              nco_phase_wr_en,
    input  logic [NUM_QUBIT_PER_BANK-1:0]              nco_z_corr_wr_en,
    input  logic [NUM_QUBIT_PER_BANK-1:0]              nco_z_corr_mode,
    input  logic [NUM_QUBIT_PER_BANK-1:0]              z_corr_clr,
    input  logic                                       cfg_wr_en,
    input  logic                                       cfg_sel,
    input  logic [QUBIT_ADDR_WIDTH_PER_BANK-1:0]       cfg_addr,
    input  logic [PHASE_WIDTH-1:0]                     cfg_data,
    output logic [NUM_QUBIT_PER_BANK*PHASE_WIDTH-1:0]  phase_out,
    output logic [NUM_QUBIT_PER_BANK-1:0]              phase_out_valid
);
    // Out-of-range addresses match no lane, so those writes fall away.
    for (genvar g = 0; g < NUM_QUBIT_PER_BANK; g++) begin : g_lane
        logic hit;
        assign hit = cfg_wr_en && (cfg_addr == QUBIT_ADDR_WIDTH_PER_BANK'(g));

        drive_nco_z_corr_lane #(.PHASE_WIDTH(PHASE_WIDTH)) u_lane (
            .clk       (clk),
            .rst       (rst),
            .freq_we   (hit && !cfg_sel),
            .det_we    (hit && cfg_sel),
            .cfg_data  (cfg_data),
            .phase_en  (nco_phase_wr_en[g]),
            .zc_en     (nco_z_corr_wr_en[g]),
            .zc_mode   (nco_z_corr_mode[g]),
            .zc_clr    (z_corr_clr[g]),
            .phase_out (phase_out[g*PHASE_WIDTH +: PHASE_WIDTH]),
            .phase_vld (phase_out_valid[g])
        );
    end
endmodule

// File: tb/tb_drive_nco_z_corr_bank.sv
// Directed bench for drive_nco_z_corr_bank with an 8-lane bank and a
// cycle scoreboard of expected phase_out / phase_out_valid.

module tb_drive_nco_z_corr_bank;
    localparam int N  = 8;
    localparam int AW = 4;
    localparam int PW = 24;

    logic              clk = 1'b0;
    logic              rst;
    logic [N-1:0]      ph_en, zc_en, zc_mode, zc_clr;
    logic              cfg_wr_en, cfg_sel;
    logic [AW-1:0]     cfg_addr;
    logic [PW-1:0]     cfg_data;
    logic [N*PW-1:0]   phase_out;
    logic [N-1:0]      phase_out_valid;

    typedef struct {
        logic [N*PW-1:0] out;
        logic [N-1:0]    vld;
    } exp_t;

    exp_t        sb[$];
    logic [PW-1:0] m_freq[N], m_det[N], m_acc[N], m_zc[N];
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    drive_nco_z_corr_bank #(
        .NUM_QUBIT_PER_BANK(N), .QUBIT_ADDR_WIDTH_PER_BANK(AW), .PHASE_WIDTH(PW)
    ) dut (
        .clk(clk), .rst(rst),
        .nco_phase_wr_en(ph_en), .nco_z_corr_wr_en(zc_en),
        .nco_z_corr_mode(zc_mode), .z_corr_clr(zc_clr),
        .cfg_wr_en(cfg_wr_en), .cfg_sel(cfg_sel), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
        .phase_out(phase_out), .phase_out_valid(phase_out_valid)
    );

    function automatic logic [PW-1:0] lane(input logic [N*PW-1:0] v, input int i);
        return v[i*PW +: PW];
    endfunction

    task automatic chk(input string tag, input logic [N*PW-1:0] act, input logic [N*PW-1:0] exp);
        checks++;
        assert (act === exp) else begin
            errors++;
            $error("FAIL %s got %h exp %h", tag, act, exp);
        end
    endtask

    task automatic idle_inputs();
        rst = 1'b0; ph_en = '0; zc_en = '0; zc_mode = '0; zc_clr = '0;
        cfg_wr_en = 1'b0; cfg_sel = 1'b0; cfg_addr = '0; cfg_data = '0;
    endtask

    // Predict the next output vector, advance the model, then clock and compare.
    task automatic cycle();
        exp_t e, got;
        for (int i = 0; i < N; i++) begin
            e.out[i*PW +: PW] = rst ? '0 : m_acc[i] + m_zc[i];
            e.vld[i]          = rst ? 1'b0 : ph_en[i];
        end
        for (int i = 0; i < N; i++) begin
            if (rst) begin
                m_acc[i] = '0; m_zc[i] = '0;
            end else begin
                if (ph_en[i]) m_acc[i] = m_acc[i] + m_freq[i];
                if (zc_clr[i]) m_zc[i] = '0;
                else if (zc_en[i] && !zc_mode[i]) m_zc[i] = m_zc[i] + m_det[i];
            end
        end
        for (int i = 0; i < N; i++) begin
            if (rst) begin
                m_freq[i] = '0; m_det[i] = '0;
            end else if (cfg_wr_en && int'(cfg_addr) == i) begin
                if (cfg_sel) m_det[i] = cfg_data;
                else         m_freq[i] = cfg_data;
            end
        end
        sb.push_back(e);
        @(posedge clk);
        #1;
        got = sb.pop_front();
        chk("sb_phase_out", phase_out, got.out);
        chk("sb_valid", {{(N*PW-N){1'b0}}, phase_out_valid}, {{(N*PW-N){1'b0}}, got.vld});
    endtask

    task automatic cfg_write(input logic sel, input logic [AW-1:0] addr, input logic [PW-1:0] data);
        cfg_wr_en = 1'b1; cfg_sel = sel; cfg_addr = addr; cfg_data = data;
        cycle();
        cfg_wr_en = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < N; i++) begin
            m_freq[i] = '0; m_det[i] = '0; m_acc[i] = '0; m_zc[i] = '0;
        end
        idle_inputs();
        rst = 1'b1;
        cycle();
        cycle();
        chk("reset_out", phase_out, '0);
        rst = 1'b0;

        // Lane 3: four advances of 0x100.
        cfg_write(1'b0, 4'd3, 24'h000100);
        ph_en[3] = 1'b1;
        repeat (4) cycle();
        chk("q3_out_0x300", lane(phase_out, 3), 24'h000300);
        ph_en[3] = 1'b0;
        cycle();
        chk("q3_out_0x400", lane(phase_out, 3), 24'h000400);
        chk("q3_others_zero", phase_out & ~({{(N*PW-PW){1'b0}}, {PW{1'b1}}} << (3*PW)), '0);

        // Lane 0: wrap-around.
        cfg_write(1'b0, 4'd0, 24'hFFFFFF);
        ph_en[0] = 1'b1;
        cycle();
        chk("q0_valid_hi", phase_out_valid[0], 1'b1);
        cycle();
        ph_en[0] = 1'b0;
        cycle();
        chk("q0_wrap", lane(phase_out, 0), 24'hFFFFFE);
        chk("q0_valid_lo", phase_out_valid[0], 1'b0);

        // Lane 5: integrate, then hold.
        cfg_write(1'b1, 4'd5, 24'h000010);
        zc_en[5] = 1'b1; zc_mode[5] = 1'b0;
        repeat (3) cycle();
        zc_mode[5] = 1'b1;
        repeat (3) cycle();
        chk("q5_hold_0x30", lane(phase_out, 5), 24'h000030);
        zc_mode[5] = 1'b0; zc_clr[5] = 1'b1;
        cycle();
        zc_clr[5] = 1'b0; zc_en[5] = 1'b0;
        cycle();
        chk("q5_clr_wins", lane(phase_out, 5), 24'h000000);
        zc_en[5] = 1'b1;
        cycle();
        zc_en[5] = 1'b0;
        cycle();
        chk("q5_resume", lane(phase_out, 5), 24'h000010);

        // Lane 2: same-cycle config write uses old frequency.
        cfg_write(1'b0, 4'd2, 24'h000010);
        ph_en[2] = 1'b1;
        cfg_write(1'b0, 4'd2, 24'h000020);
        cycle();
        ph_en[2] = 1'b0;
        cycle();
        chk("q2_old_then_new", lane(phase_out, 2), 24'h000030);
        ph_en[2] = 1'b1;
        cycle();
        ph_en[2] = 1'b0;
        cycle();
        chk("q2_plus_0x20", lane(phase_out, 2), 24'h000050);

        // Out-of-range address writes nothing.
        cfg_write(1'b0, 4'd15, 24'hABCDEF);
        cfg_write(1'b1, 4'd15, 24'hABCDEF);
        ph_en = '1; zc_en = '1;
        cycle();
        ph_en = '0; zc_en = '0;
        cycle();
        chk("oob_q7_zero", lane(phase_out, 7), 24'h000000);

        // Reset mid-run with everything asserted.
        ph_en = '1; zc_en = '1; zc_mode = '0;
        cycle();
        rst = 1'b1; cfg_wr_en = 1'b1; cfg_sel = 1'b0; cfg_addr = 4'd1; cfg_data = 24'h123456;
        cycle();
        chk("rst_out_zero", phase_out, '0);
        chk("rst_vld_zero", {{(N*PW-N){1'b0}}, phase_out_valid}, '0);
        rst = 1'b0; cfg_wr_en = 1'b0;
        repeat (2) cycle();
        chk("post_rst_cfg_cleared", phase_out, '0);
        idle_inputs();
        cycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/drive_nco_z_corr_bank.md
Name: drive_nco_z_corr_bank

Overview:
- Per-bank bank of numerically controlled oscillator (NCO) phase accumulators for the drive circuit.
- Consumes the per-qubit control vectors nco_phase_wr_en, nco_z_corr_wr_en and nco_z_corr_mode from the drive-control z-correction logic.
- Per qubit, it advances a carrier phase and integrates a virtual-Z correction (measurement-induced detuning).
- It outputs the corrected phase for every qubit to the drive envelope/mixer stage.

Parameters:
- NUM_QUBIT_PER_BANK, 16, number of qubits (NCO channels) in the bank.
- QUBIT_ADDR_WIDTH_PER_BANK, 4, width of the qubit index; must satisfy 2^width >= NUM_QUBIT_PER_BANK.
- PHASE_WIDTH, 24, width of the phase accumulator, frequency word, detuning word and z-correction register.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- nco_phase_wr_en  in  NUM_QUBIT_PER_BANK  per-qubit phase advance enable.
- nco_z_corr_wr_en  in  NUM_QUBIT_PER_BANK  per-qubit z-correction update enable.
- nco_z_corr_mode  in  NUM_QUBIT_PER_BANK  per-qubit mode: 0 = integrate detuning, 1 = hold correction.
- z_corr_clr  in  NUM_QUBIT_PER_BANK  per-qubit synchronous clear of the z-correction register.
- cfg_wr_en  in  1  configuration write strobe.
- cfg_sel  in  1  configuration target: 0 = frequency word, 1 = detuning word.
- cfg_addr  in  QUBIT_ADDR_WIDTH_PER_BANK  qubit index for the configuration write.
- cfg_data  in  PHASE_WIDTH  configuration data.
- phase_out  out  NUM_QUBIT_PER_BANK*PHASE_WIDTH  corrected phase; qubit i occupies bits [i*PHASE_WIDTH +: PHASE_WIDTH].
- phase_out_valid  out  NUM_QUBIT_PER_BANK  per-qubit valid flag for phase_out.

Behaviour:
- Clocking and reset: one clock domain (clk); reset is synchronous and active-high (rst).
- Reset clears all of the following to 0: freq[i], detune[i], phase_acc[i], z_corr[i], phase_out, phase_out_valid. rst overrides every other input in the same cycle. Asserting reset mid-accumulation drops all state and discards any cfg write in that cycle.
- Config writes:
  - When cfg_wr_en=1, cfg_data is written to freq[cfg_addr] (cfg_sel=0) or detune[cfg_addr] (cfg_sel=1).
  - If cfg_addr >= NUM_QUBIT_PER_BANK, the write is ignored.
  - A written value takes effect starting the next cycle. The accumulation in the write cycle uses the old value.
- Phase accumulator, per qubit i, per cycle:
  - If nco_phase_wr_en[i]=1: phase_acc[i] <= phase_acc[i] + freq[i], modulo 2^PHASE_WIDTH (wrap silently).
  - Otherwise phase_acc[i] holds (it is not cleared).
- Z-correction register, per qubit i, first matching rule wins:
  - z_corr_clr[i]=1: z_corr[i] <= 0. Clear has priority over update.
  - nco_z_corr_wr_en[i]=1 and nco_z_corr_mode[i]=0: z_corr[i] <= z_corr[i] + detune[i], modulo 2^PHASE_WIDTH.
  - Otherwise z_corr[i] holds. This covers mode=1 and wr_en=0.
- Outputs:
  - phase_out[i] <= phase_acc[i] + z_corr[i], modulo 2^PHASE_WIDTH, computed from pre-update register values. Latency is 1 cycle from register to output, so an input enable at edge N is reflected in phase_out at edge N+2.
  - phase_out_valid[i] <= nco_phase_wr_en[i], a 1-cycle registered copy. When it is 0, phase_out[i] still updates but downstream ignores it.
- Independence: channels are fully independent, and any mix of enables across qubits in the same cycle is legal.
- Arithmetic: all sums are unsigned with the carry discarded. There is no saturation.

Test Plan:
- Reset, then freq[3]=0x000100 via cfg, phase_wr_en[3]=1 for 4 cycles -> phase_acc[3]=0x000400. phase_out[3] reads 0x000300 one cycle after the 4th enable edge, then 0x000400. All other channels stay 0.
- freq[0]=0xFFFFFF, phase_wr_en[0]=1 for 2 cycles -> phase_acc[0]=0xFFFFFE (wrap). phase_out_valid[0]=1 delayed by one cycle.
- detune[5]=0x000010, z_corr_wr_en[5]=1, mode[5]=0 for 3 cycles, then mode[5]=1 for 3 cycles -> z_corr[5]=0x000030 and held. With freq[5]=0, phase_out[5]=0x000030.
- z_corr_clr[5]=1 while z_corr_wr_en[5]=1 and mode[5]=0 -> z_corr[5]=0 (clear wins). Accumulation resumes from 0 on the next cycle.
- Same-cycle cfg write freq[2]=0x20 (old 0x10) with phase_wr_en[2]=1 -> acc +0x10 in that cycle, then +0x20 per cycle. A cfg write with cfg_addr=15 and NUM_QUBIT_PER_BANK=8 changes nothing.
- rst asserted mid-run with all enables high -> next cycle all phase_acc, z_corr, freq, detune, phase_out and phase_out_valid are 0.
